// File: rtl/lut_settle_eval.sv
// lut_settle_eval: serially reloadable N-input truth-table gate with settling filter and toggle counter
module lut_settle_eval #(
  parameter int N_IN = 3,
  parameter int SETTLE = 4,
  parameter logic [2**N_IN-1:0] INIT_TT = '0,
  parameter int TOG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  in,
  input  logic             tt_start,
  input  logic             tt_bit,
  input  logic             tt_valid,
  output logic             tt_ready,
  output logic             tt_busy,
  output logic             tt_done,
  output logic             out,
  output logic             out_stable,
  output logic [TOG_W-1:0] tog_cnt
);
  localparam int TT_W = 2**N_IN;
  localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  typedef enum logic {RUN, LOAD} state_t;
  state_t state, state_nx;
  logic [TT_W-1:0] active_tt, shadow, merged;
  logic [N_IN:0] idx;
  logic [CW-1:0] cnt;
  logic cand, accept, last;
  assign cand = active_tt[in];
  assign out_stable = cand == out;
  assign tt_ready = state == LOAD;
  assign tt_busy = state == LOAD;
  // a start in the same cycle as a valid bit wins; the bit is dropped
  always_comb begin
    accept = state == LOAD && tt_valid && !tt_start;
    last = accept && idx == (N_IN+1)'(TT_W-1);
    state_nx = tt_start ? LOAD : last ? RUN : state;
    merged = shadow;
    merged[TT_W-1] = tt_bit;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      active_tt <= INIT_TT;
      shadow <= '0;
      idx <= '0;
      tt_done <= 1'b0;
    end else begin
      state <= state_nx;
      tt_done <= last;
      if (tt_start) idx <= '0;
      else if (accept) begin
        shadow[idx[N_IN-1:0]] <= tt_bit;
        idx <= idx + 1'b1;
      end
      if (last) active_tt <= merged;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= 1'b0;
      cnt <= '0;
      tog_cnt <= '0;
    end else if (out_stable) cnt <= '0;
    else if (cnt == CW'(SETTLE-1)) begin
      out <= ~out;
      cnt <= '0;
      if (tog_cnt != '1) tog_cnt <= tog_cnt + 1'b1;
    end else cnt <= cnt + 1'b1;
  end
endmodule

// File: tb/tb_lut_settle_eval.sv
// tb_lut_settle_eval: directed scenario bench for lut_settle_eval (N_IN=3, SETTLE=4, INIT_TT=0)
module tb_lut_settle_eval;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] in = 3'b111;
  logic tt_start = 1'b0, tt_bit = 1'b0, tt_valid = 1'b0;
  logic tt_ready, tt_busy, tt_done, out, out_stable;
  logic [7:0] tog_cnt;
  int n_pass = 0, n_chk = 0;

  lut_settle_eval #(.N_IN(3), .SETTLE(4), .INIT_TT(8'h00), .TOG_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .tt_start(tt_start), .tt_bit(tt_bit),
    .tt_valid(tt_valid), .tt_ready(tt_ready), .tt_busy(tt_busy), .tt_done(tt_done),
    .out(out), .out_stable(out_stable), .tog_cnt(tog_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    else n_pass++;
  endtask

  task automatic load_tt(input logic [7:0] v);
    tt_start = 1'b1;
    step();
    tt_start = 1'b0;
    tt_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tt_bit = v[i];
      step();
    end
    tt_valid = 1'b0;
  endtask

  task automatic test_reset();
    in = 3'b111;
    rst_n = 1'b0;
    #1;
    chk("rst_out", out, 0);
    chk("rst_stable", out_stable, 1);
    chk("rst_ready", tt_ready, 0);
    chk("rst_busy", tt_busy, 0);
    chk("rst_done", tt_done, 0);
    chk("rst_tog", tog_cnt, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rst_hold_out", out, 0);
      chk("rst_hold_stable", out_stable, 1);
      chk("rst_hold_ready", tt_ready, 0);
      chk("rst_hold_tog", tog_cnt, 0);
    end
  endtask

  task automatic test_load();
    logic [7:0] v = 8'h87;
    int ready_cnt = 0;
    in = 3'b000;
    tt_start = 1'b1;
    tt_valid = 1'b1;
    tt_bit = v[0];
    step();
    tt_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tt_bit = v[i];
      if (tt_ready === 1'b1) ready_cnt++;
      chk("load_done_early", tt_done, 0);
      chk("load_out_old", out, 0);
      step();
    end
    tt_valid = 1'b0;
    chk("load_ready_cycles", ready_cnt, 8);
    chk("load_ready_off", tt_ready, 0);
    chk("load_busy_off", tt_busy, 0);
    chk("load_done_pulse", tt_done, 1);
    chk("load_out_commit", out, 0);
    chk("load_unstable", out_stable, 0);
    step();
    chk("load_done_once", tt_done, 0);
    chk("load_out_c1", out, 0);
    step();
    chk("load_out_c2", out, 0);
    step();
    chk("load_out_c3", out, 0);
    step();
    chk("load_out_c4", out, 1);
    chk("load_tog", tog_cnt, 1);
    chk("load_stable", out_stable, 1);
  endtask

  task automatic test_glitch();
    in = 3'b011;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("glitch_stable_low", out_stable, 0);
      chk("glitch_out_hold", out, 1);
      step();
    end
    in = 3'b000;
    #1;
    chk("glitch_stable_back", out_stable, 1);
    chk("glitch_out", out, 1);
    chk("glitch_tog", tog_cnt, 1);
    step();
    chk("glitch_out_after", out, 1);
    in = 3'b011;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_out_pre", out, 1);
    end
    step();
    chk("hold_out_fall", out, 0);
    chk("hold_tog", tog_cnt, 2);
  endtask

  task automatic test_reset_mid();
    in = 3'b000;
    repeat (4) step();
    chk("mid_pre_out", out, 1);
    tt_start = 1'b1;
    step();
    tt_start = 1'b0;
    tt_valid = 1'b1;
    tt_bit = 1'b1;
    in = 3'b011;
    step();
    step();
    chk("mid_busy", tt_busy, 1);
    chk("mid_settling", out_stable, 0);
    chk("mid_out_old", out, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", out, 0);
    chk("mid_rst_tog", tog_cnt, 0);
    chk("mid_rst_ready", tt_ready, 0);
    chk("mid_rst_busy", tt_busy, 0);
    chk("mid_rst_done", tt_done, 0);
    tt_valid = 1'b0;
    step();
    rst_n = 1'b1;
    in = 3'b000;
    repeat (5) step();
    chk("mid_init_tt_stable", out_stable, 1);
    chk("mid_init_tt_out", out, 0);
    chk("mid_init_ready", tt_ready, 0);
  endtask

  task automatic test_restart();
    in = 3'b000;
    tt_start = 1'b1;
    step();
    tt_start = 1'b0;
    tt_valid = 1'b1;
    tt_bit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("rs_out_old", out, 0);
      step();
    end
    tt_start = 1'b1;
    step();
    tt_start = 1'b0;
    chk("rs_busy", tt_busy, 1);
    tt_bit = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("rs_no_early_done", tt_done, 0);
      chk("rs_out_during", out, 0);
    end
    step();
    tt_valid = 1'b0;
    chk("rs_done", tt_done, 1);
    repeat (4) step();
    chk("rs_out_new", out, 1);
    for (int i = 0; i < 8; i++) begin
      in = 3'(i);
      #1;
      chk("rs_table_ff", out_stable, 1);
    end
  endtask

  task automatic test_saturation();
    in = 3'b000;
    load_tt(8'h87);
    step();
    chk("sat_start_tog", tog_cnt, 1);
    for (int k = 0; k < 300; k++) begin
      in = (k % 2 == 0) ? 3'b011 : 3'b000;
      repeat (4) step();
      if (k == 99) chk("sat_tog_101", tog_cnt, 101);
    end
    chk("sat_tog_max", tog_cnt, 255);
    chk("sat_out", out, 1);
    chk("sat_stable", out_stable, 1);
  endtask

  initial begin
    test_reset();
    test_load();
    test_glitch();
    test_reset_mid();
    test_restart();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/lut_settle_eval.md
Name: lut_settle_eval

Overview:
- Parametrised, reprogrammable N-input truth-table gate with a settling filter, for the logic-gate library.
- Truth table is held in a register, reloaded at run time over a serial valid/ready port, and committed atomically.
- Output follows the table only after the new value has held for SETTLE consecutive cycles, which models slow gate switching and suppresses input glitches.
- Also counts output transitions for characterisation.

Parameters:
- N_IN, 3, number of logic inputs (1..6); table width TT_W = 2**N_IN.
- SETTLE, 4, consecutive cycles a differing lookup must persist before out changes (>=1).
- INIT_TT, {TT_W{1'b0}}, truth table after reset; bit i = output for input value i.
- TOG_W, 8, width of transition counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in  input  N_IN  logic inputs, synchronous to clk; in[N_IN-1] is MSB of table index.
- tt_start  input  1  one-cycle pulse: begin (or restart) table load.
- tt_bit  input  1  serial table bit, index 0 first.
- tt_valid  input  1  tt_bit valid.
- tt_ready  output  1  high while in LOAD.
- tt_busy  output  1  high while in LOAD.
- tt_done  output  1  one-cycle pulse in the cycle after commit.
- out  output  1  filtered gate output.
- out_stable  output  1  high when lookup equals out (settle count 0).
- tog_cnt  output  TOG_W  saturating count of out transitions.

Behaviour:
- Reset (async assert, sync release):
  - active table = INIT_TT; shadow = 0; state = RUN.
  - Outputs: out=0, cnt=0, out_stable=1, tog_cnt=0, tt_ready=0, tt_busy=0, tt_done=0.
- Lookup: cand = active_tt[in], combinational from the registered table.
- Settle filter, per cycle:
  - cand==out: cnt<=0.
  - cand!=out and cnt<SETTLE-1: cnt<=cnt+1.
  - cand!=out and cnt==SETTLE-1: out<=~out, cnt<=0, tog_cnt<=tog_cnt+1 (saturates at all-ones).
  - Any cycle with cand==out restarts the count; glitches shorter than SETTLE cycles never reach out.
  - Latency: a lookup change stable from cycle t appears on out at t+SETTLE. SETTLE=1 gives a plain one-cycle registered output.
- out_stable = (cand==out), combinational.
- FSM states:
  - RUN: tt_ready=0; tt_valid ignored. tt_start -> LOAD with idx<=0.
  - LOAD: tt_ready=1, tt_busy=1.
    - Accept on tt_valid&&tt_ready: shadow[idx]<=tt_bit, idx<=idx+1.
    - On accepting idx==TT_W-1: active_tt<=shadow with the last bit merged, same edge, and state <= RUN.
    - tt_done=1 for the following cycle.
  - tt_start in LOAD: restart from idx 0, partial data discarded; a tt_valid in the same cycle is not accepted.
- The old table stays active throughout LOAD. The filter keeps running and is not reset by commit. A commit that changes cand starts a normal SETTLE count.
- tt_start and tt_valid in the same RUN cycle: only the start takes effect.
- Reset mid-LOAD: load aborted, table reverts to INIT_TT, out reverts to 0.
- idx width is N_IN+1 bits; no wrap beyond TT_W-1 because commit exits LOAD.

Test Plan:
- Reset with INIT_TT=8'h00, N_IN=3, SETTLE=4, in=3'b111 -> out=0, out_stable=1, tt_ready=0, tog_cnt=0, held for 10 cycles.
- Load 8'h87 (bits LSB-first 1,1,1,0,0,0,0,1), tt_valid always high, in=3'b000 -> tt_ready high for exactly 8 cycles; tt_done pulses 1 cycle after the 8th accept; out rises exactly 4 cycles after commit; tog_cnt=1.
- Table 8'h87 with out settled to 1 at in=000; pulse in=3'b011 for 3 cycles then return to 000 -> out stays 1, out_stable low 3 cycles, tog_cnt unchanged. Hold 011 for 4 cycles -> out falls at cycle 4.
- Midway through load (after 5 bits), assert tt_start, then send 8'hFF -> final active table 8'hFF, not a mix. During load, out follows the old table.
- Assert rst_n=0 asynchronously mid-load and mid-settle -> all outputs return to reset values immediately; after release the table is INIT_TT.
- Toggle in between 000 and 011 with holds of SETTLE cycles, 300 times, TOG_W=8 -> tog_cnt saturates at 255.
